// File: rtl/conv_pkg.sv
// Shared defaults, derived output dimension and the streamer state type.
// Optional build macro used by conv_out_streamer: CONV_OUT_RELU_EN.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_H          = 32;
  localparam int DEF_W          = 32;
  localparam int DEF_F          = 5;
  localparam int DEF_OUT_DIM    = DEF_W - DEF_F + 1;
  localparam int COORD_WIDTH    = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage : conv_pkg

// File: rtl/raster_counter.sv
// Row/column raster position over a DIM x DIM frame with registered last-pixel flag.
module raster_counter
  import conv_pkg::*;
#(
  parameter int DIM = DEF_OUT_DIM,
  parameter int CW  = COORD_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          step_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  localparam logic [CW-1:0] MAX_C  = CW'(DIM - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          last_q, last_d;

  // Next position: restart, advance with wrap, or hold; last flag follows the new position.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = ZERO_C;
      col_d = ZERO_C;
    end else if (step_i) begin
      if (last_q) begin
        row_d = ZERO_C;
        col_d = ZERO_C;
      end else if (col_q == MAX_C) begin
        row_d = row_q + ONE_C;
        col_d = ZERO_C;
      end else begin
        col_d = col_q + ONE_C;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
    last_d = (row_d == MAX_C) && (col_d == MAX_C);
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= ZERO_C;
      col_q  <= ZERO_C;
      last_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      last_q <= last_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = last_q;

endmodule : raster_counter

// File: rtl/conv_out_streamer.sv
// Captures a finished convolution frame and streams it pixel by pixel over valid/ready.
// Define CONV_OUT_RELU_EN to clamp negative pixels to zero on the way out.
module conv_out_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H          = DEF_H,
  parameter int W          = DEF_W,
  parameter int F          = DEF_F,
  localparam int OUT_DIM   = ((H < W) ? H : W) - F + 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    convDone,
  input  logic [OUT_DIM*OUT_DIM*DATA_WIDTH-1:0]   convData,
  input  logic                                    outReady,
  output logic                                    outValid,
  output logic [DATA_WIDTH-1:0]                   outPixel,
  output logic [COORD_WIDTH-1:0]                  outRow,
  output logic [COORD_WIDTH-1:0]                  outCol,
  output logic                                    outLast,
  output logic                                    busy,
  output logic                                    overrun
);

  localparam int FRAME_BITS = OUT_DIM * OUT_DIM * DATA_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] relu_f(input logic [DATA_WIDTH-1:0] p);
`ifdef CONV_OUT_RELU_EN
    relu_f = p[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : p;
`else
    relu_f = p;
`endif
  endfunction

  state_e                  state_q;
  logic [FRAME_BITS-1:0]   frame_q;
  logic [DATA_WIDTH-1:0]   pix_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    overrun_q;
  logic                    hs_s;
  logic                    start_s;
  logic                    last_s;

  assign hs_s    = valid_q & outReady;
  assign start_s = (state_q == IDLE) & convDone;

  raster_counter #(
    .DIM (OUT_DIM),
    .CW  (COORD_WIDTH)
  ) u_raster (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (start_s),
    .step_i  (hs_s),
    .row_o   (outRow),
    .col_o   (outCol),
    .last_o  (last_s)
  );

  // Frame FSM; the held frame shifts up so the next pixel always sits at the MSB end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      frame_q   <= {FRAME_BITS{1'b0}};
      pix_q     <= {DATA_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (convDone) begin
            state_q <= STREAM;
            frame_q <= convData << DATA_WIDTH;
            pix_q   <= relu_f(convData[FRAME_BITS-1 -: DATA_WIDTH]);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        STREAM: begin
          if (convDone) begin
            overrun_q <= 1'b1;
          end
          if (hs_s) begin
            if (last_s) begin
              state_q <= IDLE;
              pix_q   <= {DATA_WIDTH{1'b0}};
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              pix_q   <= relu_f(frame_q[FRAME_BITS-1 -: DATA_WIDTH]);
              frame_q <= frame_q << DATA_WIDTH;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign outValid = valid_q;
  assign outPixel = pix_q;
  assign outLast  = last_s;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule : conv_out_streamer

// File: doc/conv_out_streamer.md
CONV_OUT_STREAMER -- requirements
Module: conv_out_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the pixel width in bits, signed two's complement.
REQ-002 The block SHALL have parameter H, default 32, meaning the input image height.
REQ-003 The block SHALL have parameter W, default 32, meaning the input image width.
REQ-004 The block SHALL have parameter F, default 5, meaning the filter size; OUT_DIM = W-F+1 (28 by default), with H = W required.
REQ-005 The block SHALL have port clk, input, width 1, meaning the single clock (rising edge).
REQ-006 The block SHALL have port reset, input, width 1, meaning the asynchronous active-low reset.
REQ-007 The block SHALL have port convDone, input, width 1, meaning a one-cycle pulse that convData holds a complete output frame.
REQ-008 The block SHALL have port convData, input, width OUT_DIM*OUT_DIM*DATA_WIDTH, meaning the flat frame: pixel 0 at the MSB end, row-major, DATA_WIDTH bits per pixel.
REQ-009 The block SHALL have port outReady, input, width 1, meaning the downstream consumer accepts the pixel.
REQ-010 The block SHALL have port outValid, output, width 1, meaning outPixel, outRow and outCol are valid.
REQ-011 The block SHALL have port outPixel, output, width DATA_WIDTH, meaning the current pixel.
REQ-012 The block SHALL have ports outRow and outCol, outputs, width 6 each, meaning the coordinates of the current pixel.
REQ-013 The block SHALL have port outLast, output, width 1, meaning the current pixel is pixel OUT_DIM*OUT_DIM-1.
REQ-014 The block SHALL have port busy, output, width 1, meaning a frame is held or being streamed.
REQ-015 The block SHALL have port overrun, output, width 1, meaning a sticky flag for a convDone that was dropped.

Function
REQ-016 The block SHALL implement the states IDLE and STREAM; busy SHALL be 1 exactly when the state is STREAM.
REQ-017 In IDLE, convDone=1 at a rising edge SHALL snapshot convData into an internal frame register, set row/col to 0, and enter STREAM; outValid SHALL be 1 from the next cycle (one-cycle latency).
REQ-018 In STREAM, outValid SHALL be 1, and outPixel/outRow/outCol/outLast SHALL stay stable while outReady=0.
REQ-019 A handshake (outValid & outReady at a rising edge) SHALL advance to the next pixel: col+1; at col=OUT_DIM-1, col wraps to 0 and row+1.
REQ-020 A handshake with outLast=1 SHALL return to IDLE, with outValid=0 on the next cycle.
REQ-021 convData changes after the snapshot SHALL NOT affect the streamed pixels.
REQ-022 convDone=1 in STREAM SHALL be ignored and SHALL set overrun=1 until reset; this includes convDone in the same cycle as the final handshake.
REQ-023 With outReady held at 1, one pixel SHALL be delivered per cycle; a full frame SHALL take OUT_DIM*OUT_DIM cycles after the entry cycle.

Reset
REQ-024 reset=0 SHALL asynchronously force the state to IDLE, and set outValid, outLast, busy, overrun, outRow, outCol and outPixel to 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; the first convDone after release SHALL start a fresh frame at pixel (0,0).

Configuration
REQ-026 With macro CONV_OUT_RELU_EN defined, outPixel SHALL be 0 whenever the selected pixel is negative (MSB=1); otherwise outPixel SHALL be the pixel unchanged.
REQ-027 Without CONV_OUT_RELU_EN, outPixel SHALL always equal the stored pixel, including negative values.

Structure
REQ-028 The shared package conv_pkg SHALL hold the default DATA_WIDTH/H/W/F, the derived OUT_DIM and the state enum type.
REQ-029 Row/col stepping, wrap and last detection SHALL live in one sub-module, raster_counter.

Verification
REQ-030 The bench SHALL cover: pixel k = k (0..783), convDone, outReady=1 -> 784 beats, values 0..783, (row,col) = (k/28, k%28), outLast only on beat 783, then busy=0.
REQ-031 The bench SHALL cover: outReady toggled 1,0,0,1 repeatedly -> no pixel skipped or duplicated, and outputs unchanged during stalls.
REQ-032 The bench SHALL cover: convData rewritten to all 0xFFFF one cycle after convDone -> the original frame is streamed.
REQ-033 The bench SHALL cover: a second convDone at beat 100 -> the stream is unaffected, overrun=1 and stays 1 until reset.
REQ-034 The bench SHALL cover: reset=0 at beat 300, released, then convDone -> immediate zeroed outputs, and the new frame starts at (0,0).
REQ-035 The bench SHALL cover: pixel 5 = 0x8003 -> outPixel=0x0000 with CONV_OUT_RELU_EN defined, and 0x8003 without it.
